// File: rtl/gate_tt_sweeper.sv
// Truth-table sweeper: walks every input vector onto a gate under test, holds it
// for SETTLE cycles, samples the gate output and tallies mismatches against TT.
module gate_tt_sweeper #(
    parameter int                 N_IN   = 3,
    parameter logic [2**N_IN-1:0] TT     = 8'b1111_1110,
    parameter int                 SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] x_o,
    input  logic            y_i,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_idx
);

    localparam int              CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0] X_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN-1:0]   x_d;
    logic [N_IN:0]     err_d;
    logic              fv_d;
    logic [N_IN-1:0]   fidx_d;
    logic              pass_d;
    logic              busy_d;
    logic              done_d;

    // Case-inequality so an x/z on a floating or contended net counts as a failure;
    // synthesis reduces it to a plain inequality.
    function automatic logic is_mismatch(input logic y, input logic expect_y);
        return (y !== expect_y);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_o;
        err_d   = err_cnt;
        fv_d    = fail_valid;
        fidx_d  = fail_idx;
        pass_d  = pass;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    x_d     = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fidx_d  = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    if (is_mismatch(y_i, TT[x_o])) begin
                        err_d = err_cnt + 1'b1;
                        if (!fail_valid) begin
                            fv_d   = 1'b1;
                            fidx_d = x_o;
                        end
                    end
                    // pass must include the verdict on the final vector sampled this edge
                    if (x_o == X_LAST) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_d == '0);
                    end else begin
                        x_d   = x_o + 1'b1;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            x_o        <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
            pass       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_o        <= x_d;
            err_cnt    <= err_d;
            fail_valid <= fv_d;
            fail_idx   <= fidx_d;
            pass       <= pass_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule
